// File: rtl/weight_stream_rom.sv
// Weight store with a write port and a burst read-out stream (valid/ready) to the MAC.
// Read addresses wrap modulo depth, so one weight set can feed many neurons.
module weight_stream_rom #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned LEN_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_base,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state, state_n;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0]  rd_ptr, rd_ptr_n;
   logic [LEN_W-1:0]   remaining, remaining_n;
   logic [DATA_W-1:0]  data_n;
   logic               valid_n, last_n, done_n;

   // Memory is deliberately outside the reset domain; weights survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
         rd_ptr    <= '0;
         remaining <= '0;
      end else begin
         state     <= state_n;
         out_valid <= valid_n;
         out_last  <= last_n;
         out_data  <= data_n;
         done      <= done_n;
         rd_ptr    <= rd_ptr_n;
         remaining <= remaining_n;
      end
   end

   always_comb begin
      state_n     = state;
      valid_n     = out_valid;
      last_n      = out_last;
      data_n      = out_data;
      done_n      = 1'b0;
      rd_ptr_n    = rd_ptr;
      remaining_n = remaining;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_len == '0) begin
                  done_n = 1'b1;
               end else begin
                  data_n      = mem[req_base];
                  valid_n     = 1'b1;
                  last_n      = (req_len == LEN_W'(1));
                  rd_ptr_n    = req_base + ADDR_W'(1);
                  remaining_n = req_len - LEN_W'(1);
                  state_n     = STREAM;
               end
            end
         end
         STREAM: begin
            // abort wins over a handshake landing on the same edge
            if (abort) begin
               state_n     = IDLE;
               valid_n     = 1'b0;
               last_n      = 1'b0;
               done_n      = 1'b1;
               remaining_n = '0;
            end else if (out_valid && out_ready && out_last) begin
               state_n = IDLE;
               valid_n = 1'b0;
               last_n  = 1'b0;
               done_n  = 1'b1;
            end else if (!out_valid || out_ready) begin
               if (remaining != '0) begin
                  data_n      = mem[rd_ptr];
                  valid_n     = 1'b1;
                  last_n      = (remaining == LEN_W'(1));
                  rd_ptr_n    = rd_ptr + ADDR_W'(1);
                  remaining_n = remaining - LEN_W'(1);
               end else begin
                  valid_n = 1'b0;
                  last_n  = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state == STREAM);

endmodule

// File: tb/tb_weight_stream_rom.sv
// Directed bench for weight_stream_rom: a queue-based burst model checked every cycle,
// plus literal expectations on the beats captured for each directed burst.
module tb_weight_stream_rom;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] req_base;
   logic [5:0] req_len;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;

   weight_stream_rom #(.DATA_W(8), .ADDR_W(5), .LEN_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base), .req_len(req_len),
      .abort(abort),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_mem [32];
   beat_t      exp_q [$];
   logic [7:0] got_q [$];
   bit         active = 1'b0;
   bit         done_exp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: beats of a burst are the memory contents at acceptance, one per handshake.
   always @(negedge clk) begin
      bit    nd;
      beat_t b;
      if (!rst_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_out_data", out_data, 0);
         exp_q.delete();
         active   = 1'b0;
         done_exp = 1'b0;
      end else begin
         chk("req_ready", req_ready, !active);
         chk("busy", busy, active);
         chk("done", done, done_exp);
         chk("out_valid", out_valid, exp_q.size() != 0);
         if (out_valid && exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_last", out_last, exp_q[0].l);
         end
         nd = 1'b0;
         if (active) begin
            if (abort) begin
               exp_q.delete();
               active = 1'b0;
               nd     = 1'b1;
            end else if (out_valid && out_ready && exp_q.size() != 0) begin
               got_q.push_back(out_data);
               b = exp_q.pop_front();
               if (b.l) begin
                  active = 1'b0;
                  nd     = 1'b1;
               end
            end
         end else if (req_valid) begin
            if (req_len == 0) begin
               nd = 1'b1;
            end else begin
               for (int i = 0; i < int'(req_len); i++) begin
                  b.d = model_mem[(int'(req_base) + i) % 32];
                  b.l = (i == int'(req_len) - 1);
                  exp_q.push_back(b);
               end
               active = 1'b1;
            end
         end
         done_exp = nd;
      end
      if (wr_en) model_mem[wr_addr] = wr_data;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic [4:0] base, input logic [5:0] len);
      req_valid = 1'b1;
      req_base  = base;
      req_len   = len;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int n = 0;
      while (!done && n < max_cycles) begin
         cycle();
         n++;
      end
      if (!done) chk({name, "_timeout"}, 0, 1);
      cycle();
   endtask

   task automatic chk_got(input string name, input int idx, input logic [7:0] exp);
      if (idx < got_q.size()) chk(name, got_q[idx], exp);
      else chk({name, "_missing"}, got_q.size(), idx + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
      logic [7:0] t2 [4] = '{8'd31, 8'd32, 8'd1, 8'd2};
      bit         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req_valid = 1'b0; req_base = '0; req_len = '0; abort = 1'b0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(i + 1);
         cycle();
      end
      wr_en = 1'b0;

      // T1
      got_q.delete();
      do_req(5'd0, 6'd4);
      wait_done(20, "t1");
      chk("t1_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) chk_got("t1_beat", i, t1[i]);

      // T2 wrap
      got_q.delete();
      do_req(5'd30, 6'd4);
      wait_done(20, "t2a");
      for (int i = 0; i < 4; i++) chk_got("t2_wrap_beat", i, t2[i]);
      got_q.delete();
      do_req(5'd0, 6'd40);
      wait_done(60, "t2b");
      chk("t2_long_count", got_q.size(), 40);
      chk_got("t2_beat33", 32, 8'd1);
      chk_got("t2_beat40", 39, 8'd8);

      // T3 backpressure
      got_q.delete();
      do_req(5'd3, 6'd3);
      for (int i = 0; i < 5; i++) begin
         out_ready = pat[i];
         cycle();
      end
      out_ready = 1'b1;
      wait_done(20, "t3");
      chk("t3_count", got_q.size(), 3);
      chk_got("t3_beat1", 0, 8'd4);
      chk_got("t3_beat2", 1, 8'd5);
      chk_got("t3_beat3", 2, 8'd6);

      // T4 zero length
      got_q.delete();
      do_req(5'd9, 6'd0);
      chk("t4_done", done, 1);
      chk("t4_req_ready", req_ready, 1);
      chk("t4_out_valid", out_valid, 0);
      cycle();
      chk("t4_done_once", done, 0);
      chk("t4_no_beats", got_q.size(), 0);

      // abort while idle has no effect
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("idle_abort_done", done, 0);

      // T5 abort
      got_q.delete();
      do_req(5'd10, 6'd8);
      cycle();
      cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      chk("t5_out_valid", out_valid, 0);
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      chk("t5_count", got_q.size(), 2);
      chk_got("t5_beat2", 1, 8'd12);
      cycle();
      got_q.delete();
      do_req(5'd0, 6'd1);
      wait_done(10, "t5_new");
      chk_got("t5_new_beat", 0, 8'd1);

      // T6 reset mid-burst
      do_req(5'd0, 6'd10);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid_async", out_valid, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_done_async", done, 0);
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("t6_no_done", done, 0);
      got_q.delete();
      do_req(5'd5, 6'd3);
      wait_done(20, "t6_mem");
      chk_got("t6_mem_beat1", 0, 8'd6);
      chk_got("t6_mem_beat3", 2, 8'd8);

      // write lands on the same edge a beat is loaded from that address
      got_q.delete();
      do_req(5'd20, 6'd3);
      wr_en = 1'b1; wr_addr = 5'd21; wr_data = 8'h55;
      cycle();
      wr_en = 1'b0;
      wait_done(20, "t6_wr");
      chk_got("t6_old_data", 1, 8'd22);
      got_q.delete();
      do_req(5'd21, 6'd1);
      wait_done(10, "t6_new");
      chk_got("t6_new_data", 0, 8'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
